music_queue_ctrl: RTL

MUSIC_QUEUE_CTRL -- requirements
Module: music_queue_ctrl

---
 rtl/music_queue_ctrl_if.sv | 11 +
 rtl/music_queue_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/music_queue_ctrl_if.sv
// Register bus between the host and the music queue controller.
// Host drives the write strobe, address and data; the controller returns combinational read data.
interface music_queue_ctrl_if;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output we, addr, wdata, input rdata);
   modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/music_queue_ctrl.sv
// Song-request queue and play sequencer: buffers song numbers written by the host and
// toggles the player on and off, enforcing a silent gap between consecutive songs.
//
// state | meaning
// IDLE  | waiting for a queued song
// LOAD  | pop queue head into mode
// START | one-cycle en pulse starts the player
// PLAY  | song running, wait for song_done or STOP
// STOP  | one-cycle en pulse halts the player
// GAP   | GAP_CYCLES silent clocks before next song
module music_queue_ctrl #(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   music_queue_ctrl_if.slave        bus,
   input  logic                     song_done,
   output logic                     en,
   output logic [30:0]              mode
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_PLAY  = 3'd3,
      S_STOP  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t        state, state_nxt;
   logic [30:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [GW-1:0] gap_cnt;
   logic          gap_load;
   logic          empty, full, busy;
   logic          push_req, ctrl_wr, flush, stop_req, clr_ovf, push_ok, pop_ok;
   logic [3:0]    count_field;
   logic [31:0]   status;
   logic          unused_wdata;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign busy     = (state != S_IDLE);
   assign push_req = bus.we && (bus.addr == 2'd0);
   assign ctrl_wr  = bus.we && (bus.addr == 2'd1);
   assign flush    = ctrl_wr && bus.wdata[1];
   assign stop_req = ctrl_wr && bus.wdata[0];
   assign clr_ovf  = ctrl_wr && bus.wdata[2];
   // A push alongside FLUSH is simply discarded; a push when full is dropped even if LOAD pops.
   assign push_ok  = push_req && !full && !flush;
   assign pop_ok   = (state == S_LOAD) && !empty;
   assign unused_wdata = bus.wdata[31];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= bus.wdata[30:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow <= 1'b0;
         mode     <= '0;
         gap_cnt  <= '0;
      end else begin
         if (push_req && full && !flush) overflow <= 1'b1;
         else if (clr_ovf)               overflow <= 1'b0;
         if (pop_ok) mode <= mem[rd_ptr];
         if (gap_load)                            gap_cnt <= GW'(GAP_CYCLES - 1);
         else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      en        = 1'b0;
      gap_load  = 1'b0;
      case (state)
         S_IDLE:  if (!empty) state_nxt = S_LOAD;
         // A FLUSH in the IDLE cycle can leave LOAD with nothing to pop.
         S_LOAD:  state_nxt = empty ? S_IDLE : S_START;
         S_START: begin
            en        = 1'b1;
            state_nxt = S_PLAY;
         end
         S_PLAY: begin
            if (song_done) begin
               state_nxt = S_GAP;
               gap_load  = 1'b1;
            end else if (stop_req) begin
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            en        = 1'b1;
            state_nxt = S_GAP;
            gap_load  = 1'b1;
         end
         S_GAP:   if (gap_cnt == '0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      count_field = (32'(count) > 32'd15) ? 4'd15 : 4'(count);
      status      = {20'b0, count_field, 1'b0, state, overflow, busy, full, empty};
      case (bus.addr)
         2'd2:    bus.rdata = status;
         2'd3:    bus.rdata = {1'b0, mode};
         default: bus.rdata = '0;
      endcase
   end
endmodule
